// File: rtl/multu_seq_pkg.sv
// rtl/multu_seq_pkg.sv - shared types, defaults and width helpers for the sequential multiplier
package multu_seq_pkg;

  // Default operand width of the multiplier
  localparam int DEFAULT_WIDTH = 32;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_e;

  // Smallest counter width with 2^w > width, so the count WIDTH-1 always fits
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/multu_dp.sv
// rtl/multu_dp.sv - shift-add datapath: multiplicand, accumulator and multiplier registers
module multu_dp
  import multu_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product_o
);

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mplr_q, mplr_d;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] acc_step;
  logic [WIDTH-1:0] mplr_step;

  // One shift-add iteration: add mcand when the current multiplier LSB is set,
  // then shift {sum, mplr} right by one so the sum's LSB enters the multiplier MSB
  always_comb begin
    sum       = {1'b0, acc_q} + (mplr_q[0] ? {1'b0, mcand_q} : '0);
    acc_step  = sum[WIDTH:1];
    mplr_step = {sum[0], mplr_q[WIDTH-1:1]};
  end

  // The value {acc,mplr} takes after this iteration; the last one is the final product
  assign product_o = {acc_step, mplr_step};

  // Register next-state: load on accept, iterate while running, otherwise hold
  always_comb begin
    mcand_d = mcand_q;
    acc_d   = acc_q;
    mplr_d  = mplr_q;
    if (load) begin
      mcand_d = a;
      acc_d   = '0;
      mplr_d  = b;
    end else if (step) begin
      acc_d  = acc_step;
      mplr_d = mplr_step;
    end
  end

  // Datapath registers, cleared asynchronously by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q <= '0;
      acc_q   <= '0;
      mplr_q  <= '0;
    end else begin
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      mplr_q  <= mplr_d;
    end
  end

endmodule

// File: rtl/multu_seq.sv
// rtl/multu_seq.sv - sequential unsigned multiplier with HI/LO registers and pipeline stall
module multu_seq
  import multu_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             kill,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             pipe_en,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               accept;
  logic               load;
  logic               step;
  logic               last_iter;
  logic [2*WIDTH-1:0] product;

  multu_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (step),
    .a        (a),
    .b        (b),
    .product_o(product)
  );

  // FSM next state, datapath controls, counter and HI/LO update; kill beats start
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    load      = 1'b0;
    step      = 1'b0;
    accept    = ((state_q == IDLE) || (state_q == DONE)) && start && !kill;
    last_iter = (cnt_q == CNT_W'(WIDTH - 1));
    unique case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (kill) begin
          // Aborted operation leaves HI/LO untouched and never pulses done
          state_d = IDLE;
        end else begin
          step  = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if (last_iter) begin
            hi_d    = product[2*WIDTH-1:WIDTH];
            lo_d    = product[WIDTH-1:0];
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and architectural HI/LO registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Stall is combinational so the MULTU itself is held in the cycle it is accepted
  always_comb begin
    busy    = (state_q == RUN);
    done    = (state_q == DONE);
    pipe_en = !(busy || accept);
    hi      = hi_q;
    lo      = lo_q;
  end

endmodule

// File: tb/tb_multu_seq.sv
// tb/tb_multu_seq.sv - directed self-checking bench for multu_seq
module tb_multu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        kill;
  logic [31:0] a;
  logic [31:0] b;
  logic        pipe_en;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp = 0;
  int n_err = 0;

  multu_seq dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .kill   (kill),
    .a      (a),
    .b      (b),
    .pipe_en(pipe_en),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present start for one cycle (cycle 0); returns in cycle 1
  task automatic launch(input logic [31:0] av, input logic [31:0] bv, input string tag);
    start = 1'b1;
    a     = av;
    b     = bv;
    #1;
    chk({tag, "_start_stall"}, {63'd0, pipe_en}, 64'd0);
    tick();
    start = 1'b0;
  endtask

  // Step from cycle from_cyc until done, counting non-stalled cycles on the way
  task automatic wait_done(input int from_cyc, output int at_cyc, output int open_cyc);
    int cyc;
    cyc      = from_cyc;
    open_cyc = 0;
    while (done !== 1'b1 && cyc < 60) begin
      if (pipe_en !== 1'b0) open_cyc++;
      tick();
      cyc++;
    end
    at_cyc = cyc;
  endtask

  // Full operation checked for latency, stall window and result
  task automatic do_mul(input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] eh, input logic [31:0] el, input string tag);
    int at_cyc, open_cyc;
    launch(av, bv, tag);
    wait_done(1, at_cyc, open_cyc);
    chk({tag, "_done_cycle"}, 64'(at_cyc), 64'd33);
    chk({tag, "_run_open"}, 64'(open_cyc), 64'd0);
    chk({tag, "_done_pipe_en"}, {63'd0, pipe_en}, 64'd1);
    chk({tag, "_hi"}, {32'd0, hi}, {32'd0, eh});
    chk({tag, "_lo"}, {32'd0, lo}, {32'd0, el});
  endtask

  initial begin
    int at_cyc, open_cyc, n_done;

    rst   = 1'b1;
    start = 1'b0;
    kill  = 1'b0;
    a     = '0;
    b     = '0;
    #12;
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_pipe_en", {63'd0, pipe_en}, 64'd1);
    start = 1'b1;
    #1;
    chk("rst_start_pipe_en", {63'd0, pipe_en}, 64'd0);
    kill = 1'b1;
    #1;
    chk("rst_start_kill_pipe_en", {63'd0, pipe_en}, 64'd1);
    start = 1'b0;
    kill  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Basic, maximum and zero operands
    do_mul(32'd3, 32'd5, 32'h0, 32'hF, "basic");
    tick();
    chk("after_done_idle", {62'd0, done, pipe_en}, 64'b01);
    do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "max");
    tick();
    do_mul(32'h0, 32'h1234_5678, 32'h0, 32'h0, "zero");
    tick();

    // Start during RUN is ignored
    launch(32'd7, 32'd9, "ign");
    for (int i = 1; i < 5; i++) tick();
    start = 1'b1;
    a     = 32'd2;
    b     = 32'd2;
    tick();
    start = 1'b0;
    wait_done(6, at_cyc, open_cyc);
    chk("ign_done_cycle", 64'(at_cyc), 64'd33);
    chk("ign_run_open", 64'(open_cyc), 64'd0);
    chk("ign_hi", {32'd0, hi}, 64'd0);
    chk("ign_lo", {32'd0, lo}, 64'h3F);
    n_done = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done === 1'b1) n_done++;
    end
    chk("ign_single_done", 64'(n_done), 64'd0);
    chk("ign_pipe_en_after", {63'd0, pipe_en}, 64'd1);

    // Kill at RUN cycle 10
    launch(32'd100, 32'd100, "kill");
    for (int i = 1; i < 10; i++) tick();
    kill = 1'b1;
    tick();
    kill = 1'b0;
    chk("kill_busy", {63'd0, busy}, 64'd0);
    chk("kill_pipe_en", {63'd0, pipe_en}, 64'd1);
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) n_done++;
      tick();
    end
    chk("kill_no_done", 64'(n_done), 64'd0);
    chk("kill_hi", {32'd0, hi}, 64'd0);
    chk("kill_lo", {32'd0, lo}, 64'h3F);

    // start together with kill in IDLE is not accepted
    start = 1'b1;
    kill  = 1'b1;
    #1;
    chk("idle_kill_pipe_en", {63'd0, pipe_en}, 64'd1);
    tick();
    start = 1'b0;
    kill  = 1'b0;
    chk("idle_kill_busy", {63'd0, busy}, 64'd0);

    // Asynchronous reset at RUN cycle 20
    launch(32'hFFFF, 32'hFFFF, "arst");
    for (int i = 1; i < 20; i++) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_hi", {32'd0, hi}, 64'd0);
    chk("arst_lo", {32'd0, lo}, 64'd0);
    chk("arst_done", {63'd0, done}, 64'd0);
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_pipe_en", {63'd0, pipe_en}, 64'd1);
    @(negedge clk);
    rst = 1'b0;
    tick();
    do_mul(32'd6, 32'd7, 32'd0, 32'd42, "post_rst");
    tick();

    // Back-to-back: new start in the DONE cycle
    do_mul(32'd3, 32'd5, 32'h0, 32'hF, "b2b_first");
    start = 1'b1;
    a     = 32'h0001_0000;
    b     = 32'h0001_0000;
    #1;
    chk("b2b_done_stall", {63'd0, pipe_en}, 64'd0);
    tick();
    start = 1'b0;
    chk("b2b_busy", {63'd0, busy}, 64'd1);
    wait_done(1, at_cyc, open_cyc);
    chk("b2b_done_cycle", 64'(at_cyc), 64'd33);
    chk("b2b_run_open", 64'(open_cyc), 64'd0);
    chk("b2b_hi", {32'd0, hi}, 64'd1);
    chk("b2b_lo", {32'd0, lo}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
